// File: rtl/ovf_exc_ctrl.sv
// ==========================================================================
//  Module      : ovf_exc_ctrl
//  Description : Traps on an enabled ALU signed overflow. It kills the
//                writeback, saves EPC/Cause, redirects to the handler, and
//                returns to EPC on ERET.
//  Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module ovf_exc_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
   parameter logic [4:0]  EXC_CODE_OV  = 5'd12,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   input  logic             overflow,
   input  logic             ov_enable,
   input  logic [31:0]      pc_current,
   input  logic             eret,
   output logic             exc_flush,
   output logic             pc_redirect,
   output logic [31:0]      redirect_pc,
   output logic [31:0]      epc,
   output logic [31:0]      cause,
   output logic             in_handler,
   output logic             missed_ovf,
   output logic [CNT_W-1:0] trap_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_TRAP    = 2'd1,
      S_HANDLER = 2'd2,
      S_RETURN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      epc_q, epc_d;
   logic [31:0]      cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             missed_q, missed_d;
   logic             redir_q, redir_d;
   logic [31:0]      rpc_q, rpc_d;
   logic             inh_q, inh_d;

   logic             w_ov_seen;
   logic             w_trig;

   assign w_ov_seen = alu_valid & overflow;
   // Flush is gated by reset so a held-in-reset core never drops a write.
   assign w_trig    = rst_n & w_ov_seen & ov_enable & (state_q == S_IDLE);

   always_comb begin
      state_d  = state_q;
      epc_d    = epc_q;
      cause_d  = cause_q;
      cnt_d    = cnt_q;
      missed_d = missed_q;
      unique case (state_q)
         S_IDLE: begin
            if (w_trig) begin
               state_d = S_TRAP;
               epc_d   = pc_current;
               cause_d = {25'b0, EXC_CODE_OV, 2'b00};
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_TRAP: begin
            state_d = S_HANDLER;
         end
         S_HANDLER: begin
            if (w_ov_seen) missed_d = 1'b1;
            if (eret) state_d = S_RETURN;
         end
         S_RETURN: begin
            if (w_ov_seen) missed_d = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Redirect outputs are decoded from the upcoming state so they appear
      // registered in the cycle that state is occupied.
      redir_d = (state_d == S_TRAP) || (state_d == S_RETURN);
      inh_d   = (state_d != S_IDLE);
      rpc_d   = '0;
      if (state_d == S_TRAP) begin
         rpc_d = HANDLER_ADDR;
      end else if (state_d == S_RETURN) begin
         rpc_d = epc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         epc_q    <= '0;
         cause_q  <= '0;
         cnt_q    <= '0;
         missed_q <= 1'b0;
         redir_q  <= 1'b0;
         rpc_q    <= '0;
         inh_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         cnt_q    <= cnt_d;
         missed_q <= missed_d;
         redir_q  <= redir_d;
         rpc_q    <= rpc_d;
         inh_q    <= inh_d;
      end
   end

   assign exc_flush   = w_trig;
   assign pc_redirect = redir_q;
   assign redirect_pc = rpc_q;
   assign epc         = epc_q;
   assign cause       = cause_q;
   assign in_handler  = inh_q;
   assign missed_ovf  = missed_q;
   assign trap_count  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ovf_exc_ctrl.sv
// ==========================================================================
//  Module      : tb_ovf_exc_ctrl
//  Description : Scoreboard bench for ovf_exc_ctrl with a cycle-level
//                reference model; a second instance uses a 2-bit counter.
//  Revision    : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_ovf_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic        overflow = 1'b0;
   logic        ov_enable = 1'b0;
   logic [31:0] pc_current = '0;
   logic        eret = 1'b0;

   logic        exc_flush, pc_redirect, in_handler, missed_ovf;
   logic [31:0] redirect_pc, epc, cause;
   logic [15:0] trap_count;

   logic        s_exc_flush, s_pc_redirect, s_in_handler, s_missed_ovf;
   logic [31:0] s_redirect_pc, s_epc, s_cause;
   logic [1:0]  s_trap_count;

   always #5 clk = ~clk;

   ovf_exc_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .overflow(overflow),
      .ov_enable(ov_enable), .pc_current(pc_current), .eret(eret),
      .exc_flush(exc_flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
      .epc(epc), .cause(cause), .in_handler(in_handler), .missed_ovf(missed_ovf),
      .trap_count(trap_count)
   );

   ovf_exc_ctrl #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .overflow(overflow),
      .ov_enable(ov_enable), .pc_current(pc_current), .eret(eret),
      .exc_flush(s_exc_flush), .pc_redirect(s_pc_redirect), .redirect_pc(s_redirect_pc),
      .epc(s_epc), .cause(s_cause), .in_handler(s_in_handler), .missed_ovf(s_missed_ovf),
      .trap_count(s_trap_count)
   );

   typedef struct {
      logic        flush;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] epc;
      logic [31:0] cause;
      logic        inh;
      logic        missed;
      logic [15:0] cnt16;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: "where is control flow heading" rather than an FSM copy.
   // busy     : a trap has been taken and not yet fully returned
   // entering : the handler-entry redirect is being presented this cycle
   // leaving  : the return redirect is being presented this cycle
   bit          m_busy, m_entering, m_leaving, m_missed;
   logic [31:0] m_epc, m_cause;
   int          m_traps;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic av, input logic ov, input logic en,
                      input logic [31:0] pc, input logic er);
      exp_t e;
      bit   take;
      rst_n = r; alu_valid = av; overflow = ov; ov_enable = en;
      pc_current = pc; eret = er;
      take = r && !m_busy && av && ov && en;
      e.flush  = take;
      e.redir  = m_entering || m_leaving;
      e.rpc    = m_entering ? 32'h0000_0180 : (m_leaving ? m_epc : 32'h0);
      e.epc    = m_epc;
      e.cause  = m_cause;
      e.inh    = m_busy;
      e.missed = m_missed;
      e.cnt16  = (m_traps > 65535) ? 16'hFFFF : 16'(m_traps);
      e.cnt2   = (m_traps > 3) ? 2'd3 : 2'(m_traps);
      exp_q.push_back(e);
      if (!r) begin
         m_busy = 0; m_entering = 0; m_leaving = 0; m_missed = 0;
         m_epc = 0; m_cause = 0; m_traps = 0;
      end else if (take) begin
         m_busy = 1; m_entering = 1; m_epc = pc; m_cause = 32'h0000_0030;
         m_traps++;
      end else if (m_entering) begin
         m_entering = 0;
      end else if (m_leaving) begin
         if (av && ov) m_missed = 1;
         m_leaving = 0; m_busy = 0;
      end else if (m_busy) begin
         if (av && ov) m_missed = 1;
         if (er) m_leaving = 1;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare it.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("exc_flush",   {31'b0, exc_flush},   {31'b0, e.flush});
         chk("pc_redirect", {31'b0, pc_redirect}, {31'b0, e.redir});
         chk("redirect_pc", redirect_pc, e.rpc);
         chk("epc",         epc,         e.epc);
         chk("cause",       cause,       e.cause);
         chk("in_handler",  {31'b0, in_handler},  {31'b0, e.inh});
         chk("missed_ovf",  {31'b0, missed_ovf},  {31'b0, e.missed});
         chk("trap_count",  {16'b0, trap_count},  {16'b0, e.cnt16});
         chk("trap_count_sat", {30'b0, s_trap_count}, {30'b0, e.cnt2});
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int r_av, r_ov, r_en, r_er, r_rs;
      m_busy = 0; m_entering = 0; m_leaving = 0; m_missed = 0;
      m_epc = 0; m_cause = 0; m_traps = 0;
      @(posedge clk);
      #1;
      // Reset, then trap at 0x40
      cyc(0, 0, 0, 0, 32'h0, 0);
      cyc(1, 1, 1, 1, 32'h0000_0040, 0);
      cyc(1, 0, 0, 0, 32'h0, 0);                 // TRAP
      cyc(1, 0, 0, 0, 32'h0, 0);                 // handler
      cyc(1, 1, 1, 1, 32'h0000_0200, 0);         // nested overflow
      cyc(1, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 32'h0, 1);                 // eret
      cyc(1, 0, 0, 0, 32'h0, 0);                 // RETURN
      cyc(1, 0, 0, 0, 32'h0, 0);
      // Masked by enable, spurious eret
      cyc(1, 1, 1, 0, 32'h0000_0300, 0);
      cyc(1, 0, 1, 1, 32'h0000_0304, 0);
      cyc(1, 0, 0, 0, 32'h0, 1);
      cyc(1, 0, 0, 0, 32'h0, 0);
      // Reset during TRAP
      cyc(1, 1, 1, 1, 32'h0000_0500, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 0, 32'h0, 0);
      // Five trap/eret rounds, back-to-back trap right after RETURN
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 1, 1, 32'h0000_1000 + 32'(i * 4), 0);
         cyc(1, 0, 0, 0, 32'h0, 0);
         cyc(1, 0, 0, 0, 32'h0, 1);
         cyc(1, 0, 0, 0, 32'h0, 0);
      end
      cyc(1, 0, 0, 0, 32'h0, 0);
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r_av = $urandom_range(0, 1);
         r_ov = ($urandom_range(0, 2) == 0);
         r_en = ($urandom_range(0, 3) != 0);
         r_er = ($urandom_range(0, 3) == 0);
         r_rs = ($urandom_range(0, 49) != 0);
         cyc(1'(r_rs), 1'(r_av), 1'(r_ov), 1'(r_en), $urandom() & 32'hFFFF_FFFC, 1'(r_er));
      end
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ovf_exc_ctrl.md
Name: ovf_exc_ctrl

Overview:
- Consumes the ALU signed-overflow flag, one per add/sub result, on the datapath's exception side.
- On an enabled overflow it suppresses the offending instruction's writeback, records EPC/Cause, and redirects the PC to the exception handler.
- On ERET it returns control to the saved EPC.
- Sits between the ALU/overflow flag and the PC-select mux / register-file write enable.

Parameters:
- HANDLER_ADDR, 32'h0000_0180, PC loaded on trap entry.
- EXC_CODE_OV, 5'd12, ExcCode written to cause[6:2] for arithmetic overflow.
- CNT_W, 16, width of saturating trap counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- alu_valid  input  1  an add/sub instruction completes in this cycle
- overflow  input  1  ALU signed overflow for that instruction
- ov_enable  input  1  overflow trap enable (status bit)
- pc_current  input  32  PC of the instruction completing this cycle
- eret  input  1  exception-return instruction completes this cycle
- exc_flush  output  1  combinational; kill regfile write of current instruction
- pc_redirect  output  1  PC mux must take redirect_pc next edge
- redirect_pc  output  32  target PC when pc_redirect=1
- epc  output  32  saved exception PC
- cause  output  32  exception cause register
- in_handler  output  1  trap active, handler executing
- missed_ovf  output  1  sticky; overflow seen while masked by an active handler
- trap_count  output  CNT_W  saturating count of traps taken

Behaviour:
- Reset: when rst_n=0 at a clk edge, all of the following are cleared.
  - state=IDLE.
  - epc=0, cause=0, trap_count=0, missed_ovf=0.
  - pc_redirect=0, redirect_pc=0, in_handler=0.
  - exc_flush=0 while in reset.
  - Reset mid-trap or mid-return aborts with no redirect issued.
- Trap condition: trig = alu_valid & overflow & ov_enable & (state==IDLE).
- exc_flush = trig, combinational and same cycle; it is never asserted outside IDLE.
- IDLE:
  - On trig, at the edge:
    - epc<=pc_current.
    - cause<={25'b0, EXC_CODE_OV, 2'b0}; cause[31] is reserved, 0.
    - trap_count<=trap_count+1, saturating at all-ones.
    - Go to TRAP.
  - eret in IDLE is ignored: no redirect, no state change.
  - overflow with ov_enable=0 or alu_valid=0: no action.
- TRAP, exactly 1 cycle:
  - pc_redirect=1, redirect_pc=HANDLER_ADDR, in_handler=1.
  - Next state is HANDLER.
- HANDLER:
  - in_handler=1, pc_redirect=0.
  - alu_valid&overflow (any ov_enable): no flush, no epc/cause update, missed_ovf<=1.
  - On eret, go to RETURN; overflow in the same cycle still sets missed_ovf.
- RETURN, exactly 1 cycle:
  - pc_redirect=1, redirect_pc=epc, in_handler=1.
  - Next state is IDLE.
  - Inputs are ignored in RETURN; overflow there sets missed_ovf.
- Output registers:
  - pc_redirect, redirect_pc and in_handler are registered, decoded from state.
  - redirect_pc is 0 when pc_redirect=0.
- epc and cause hold their values until the next trap or reset.
- missed_ovf clears only on reset.
- Latency:
  - Overflow cycle N: flush in N.
  - Redirect to handler in N+1; handler first fetch at N+2.
  - eret cycle M: redirect to epc in M+1.
- Back-to-back: trig is possible again on the first IDLE cycle after RETURN.

Test Plan:
1. Reset then trap:
   - Stimulus: rst_n=0 for 2 cycles; then alu_valid=1, overflow=1, ov_enable=1, pc_current=32'h0000_0040.
   - Response: exc_flush=1 same cycle. Next cycle pc_redirect=1, redirect_pc=32'h180, epc=32'h40, cause=32'h0000_0030, trap_count=1.
2. Masked by enable:
   - Stimulus: ov_enable=0, alu_valid=1, overflow=1.
   - Response: exc_flush=0, pc_redirect stays 0, epc/cause/trap_count unchanged.
3. ERET return:
   - Stimulus: after scenario 1, hold 3 HANDLER cycles, then eret=1 for 1 cycle.
   - Response: next cycle pc_redirect=1, redirect_pc=32'h40. Following cycle in_handler=0, state IDLE.
4. Nested overflow:
   - Stimulus: in HANDLER, overflow=1, alu_valid=1, pc_current=32'h200.
   - Response: exc_flush=0, epc stays 32'h40, missed_ovf=1 and sticky through the return.
5. Spurious ERET / reset mid-trap:
   - Stimulus: eret in IDLE; separately, rst_n=0 during TRAP.
   - Response: eret gives no redirect. Reset drives all outputs to 0 the next edge, with no handler redirect afterward.
6. Counter saturation:
   - Stimulus: CNT_W=2, take 5 trap/eret cycles.
   - Response: trap_count sequence 1, 2, 3, 3, 3.
